msrv32_integer_file: RTL and testbench

- RV32I integer register file: 32 x 32-bit general-purpose registers (x0..x31) with two combinational read ports and one synchronous write port.
- Sits in the msrv32 core between decode (rs1/rs2 addresses) and writeback (rd address and data).
- x0 is hardwired to zero.

---
 rtl/msrv32_pkg.sv | 13 +
 rtl/msrv32_integer_file.sv | 95 +++++++++
 tb/tb_msrv32_integer_file.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/msrv32_pkg.sv
// Shared msrv32 definitions: architectural width, register index width,
// the register index/data types and the index of the hardwired-zero register.
package msrv32_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;
  typedef logic [XLEN-1:0]       xlen_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/msrv32_integer_file.sv
// RV32I integer register file: x1..x31 are flops with asynchronous
// active-low clear, x0 is a constant zero. Two combinational read ports,
// one synchronous write port.
// Build option: MSRV32_INTEGER_FILE_BYPASS_EN adds write-to-read forwarding
// so a read of the register being written returns rd_in in the same cycle.
import msrv32_pkg::*;

module msrv32_integer_file #(
  parameter int DATA_WIDTH = XLEN,
  parameter int ADDR_WIDTH = REG_ADDR_W
) (
  input  logic                  ms_risc32_mp_clk_in,
  input  logic                  ms_risc32_mp_rst_in,
  input  logic [ADDR_WIDTH-1:0] rs_1_addr_in,
  input  logic [ADDR_WIDTH-1:0] rs_2_addr_in,
  input  logic [ADDR_WIDTH-1:0] rd_addr_in,
  input  logic [DATA_WIDTH-1:0] rd_in,
  input  logic                  wr_en_in,
  output logic [DATA_WIDTH-1:0] rs_1_out,
  output logic [DATA_WIDTH-1:0] rs_2_out
);

  localparam int NREG = 2 ** ADDR_WIDTH;

  // Flattened view of all registers for the read muxes; entry 0 is x0.
  logic [NREG-1:0][DATA_WIDTH-1:0] rf_flat;
  logic [DATA_WIDTH-1:0]           rd_1_raw;
  logic [DATA_WIDTH-1:0]           rd_2_raw;

  assign rf_flat[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_reg
      logic [DATA_WIDTH-1:0] reg_q;
      logic [DATA_WIDTH-1:0] reg_d;
      logic                  wr_sel;

      assign wr_sel = wr_en_in && (rd_addr_in == ADDR_WIDTH'(gi));

      // Next state: take write data when this register is the write target.
      always_comb begin
        reg_d = reg_q;
        if (wr_sel) begin
          reg_d = rd_in;
        end
      end

      // Register storage; reset clears it at once, overriding any write.
      always_ff @(posedge ms_risc32_mp_clk_in or negedge ms_risc32_mp_rst_in) begin
        if (!ms_risc32_mp_rst_in) begin
          reg_q <= '0;
        end else begin
          reg_q <= reg_d;
        end
      end

      assign rf_flat[gi] = reg_q;
    end
  endgenerate

`ifdef MSRV32_INTEGER_FILE_BYPASS_EN
  logic wr_live;
  assign wr_live = wr_en_in && (rd_addr_in != REG_ZERO[ADDR_WIDTH-1:0]);

  // Forward the in-flight write to any port reading the same register.
  always_comb begin
    rd_1_raw = rf_flat[rs_1_addr_in];
    rd_2_raw = rf_flat[rs_2_addr_in];
    if (wr_live && (rs_1_addr_in == rd_addr_in)) begin
      rd_1_raw = rd_in;
    end
    if (wr_live && (rs_2_addr_in == rd_addr_in)) begin
      rd_2_raw = rd_in;
    end
  end
`else
  // Plain read: reflect stored register contents only.
  always_comb begin
    rd_1_raw = rf_flat[rs_1_addr_in];
    rd_2_raw = rf_flat[rs_2_addr_in];
  end
`endif

  // Reset forces both read ports to zero, including any forwarded value.
  always_comb begin
    rs_1_out = '0;
    rs_2_out = '0;
    if (ms_risc32_mp_rst_in) begin
      rs_1_out = rd_1_raw;
      rs_2_out = rd_2_raw;
    end
  end

endmodule

// File: tb/tb_msrv32_integer_file.sv
// Self-checking bench for msrv32_integer_file. Expected read values are
// queued when a read is set up and popped when the outputs are sampled.
// Define MSRV32_INTEGER_FILE_BYPASS_EN for both bench and RTL to test forwarding.
module tb_msrv32_integer_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        wr_en;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;

  int checks;
  int failures;

  logic [31:0] exp_q[$];
  logic [31:0] mdl[32];

  msrv32_integer_file dut (
    .ms_risc32_mp_clk_in (clk),
    .ms_risc32_mp_rst_in (rst_n),
    .rs_1_addr_in        (rs1_addr),
    .rs_2_addr_in        (rs2_addr),
    .rd_addr_in          (rd_addr),
    .rd_in               (rd_data),
    .wr_en_in            (wr_en),
    .rs_1_out            (rs1_data),
    .rs_2_out            (rs2_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  // Set read addresses and queue what each port must show.
  task automatic drive_read(input logic [4:0] a1, input logic [4:0] a2,
                            input logic [31:0] e1, input logic [31:0] e2);
    rs1_addr = a1;
    rs2_addr = a2;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
  endtask

  // Let the combinational read settle, then pop and compare both ports.
  task automatic compare_reads(input string tag);
    logic [31:0] e1;
    logic [31:0] e2;
    #1;
    if (exp_q.size() < 2) begin
      check_value({tag, "_sb_empty"}, 32'(exp_q.size()), 32'd2);
    end else begin
      e1 = exp_q.pop_front();
      e2 = exp_q.pop_front();
      check_value({tag, "_p1"}, rs1_data, e1);
      check_value({tag, "_p2"}, rs2_data, e2);
      $display("read  %-10s x%0d=%08h x%0d=%08h", tag, rs1_addr, rs1_data, rs2_addr, rs2_data);
    end
  endtask

  // One write cycle: present at negedge, commit at posedge, drop enable.
  task automatic do_write(input logic en, input logic [4:0] a, input logic [31:0] d);
    @(negedge clk);
    wr_en   = en;
    rd_addr = a;
    rd_data = d;
    @(posedge clk);
    if (rst_n && en && a != 5'd0) mdl[a] = d;
    $display("write en=%0b x%0d <= %08h", en, a, d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    rst_n    = 1'b0;
    wr_en    = 1'b0;
    rd_addr  = 5'd0;
    rd_data  = 32'h0;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;

    // Reset state on every address.
    #15;
    drive_read(5'd0, 5'd0, 32'h0, 32'h0);
    compare_reads("rst_x0");
    for (int a = 1; a < 32; a++) begin
      drive_read(5'(a), 5'(32 - a), 32'h0, 32'h0);
      compare_reads("rst_all");
    end

    // Release reset away from the clock edge.
    @(negedge clk);
    rst_n = 1'b1;

    // Basic write/read.
    do_write(1'b1, 5'd1, 32'h0000_0005);
    do_write(1'b1, 5'd2, 32'h0000_0006);
    drive_read(5'd1, 5'd2, 32'h0000_0005, 32'h0000_0006);
    compare_reads("basic");
    drive_read(5'd2, 5'd2, 32'h0000_0006, 32'h0000_0006);
    compare_reads("same_port");

    // x0 stays zero.
    do_write(1'b1, 5'd0, 32'hDEAD_BEEF);
    drive_read(5'd0, 5'd0, 32'h0, 32'h0);
    compare_reads("x0_prot");

    // Write enable low leaves x3 untouched.
    do_write(1'b0, 5'd3, 32'h1234_5678);
    drive_read(5'd3, 5'd1, 32'h0, 32'h0000_0005);
    compare_reads("wen_low");

    // Same-address read/write.
    do_write(1'b1, 5'd4, 32'h1111_1111);
    @(negedge clk);
    wr_en   = 1'b1;
    rd_addr = 5'd4;
    rd_data = 32'hAAAA_AAAA;
`ifdef MSRV32_INTEGER_FILE_BYPASS_EN
    drive_read(5'd4, 5'd1, 32'hAAAA_AAAA, 32'h0000_0005);
`else
    drive_read(5'd4, 5'd1, 32'h1111_1111, 32'h0000_0005);
`endif
    compare_reads("rw_before");
    @(posedge clk);
    mdl[4] = 32'hAAAA_AAAA;
    @(negedge clk);
    wr_en = 1'b0;
    drive_read(5'd4, 5'd0, 32'hAAAA_AAAA, 32'h0);
    compare_reads("rw_after");

    // Randomised writes and reads against the model.
    for (int n = 0; n < 40; n++) begin
      logic [4:0] a1;
      logic [4:0] a2;
      do_write(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)), $urandom);
      a1 = 5'($urandom_range(0, 31));
      a2 = 5'($urandom_range(0, 31));
      drive_read(a1, a2, mdl[a1], mdl[a2]);
      compare_reads("random");
    end

    // Asynchronous reset in the middle of a cycle.
    do_write(1'b1, 5'd31, 32'hFFFF_FFFF);
    drive_read(5'd1, 5'd31, mdl[1], 32'hFFFF_FFFF);
    compare_reads("x31_set");
    #2;
    rst_n = 1'b0;
    for (int i = 0; i < 32; i++) mdl[i] = 32'h0;
    drive_read(5'd1, 5'd31, 32'h0, 32'h0);
    compare_reads("async_rst");

    // A write presented while reset is held must be discarded.
    wr_en   = 1'b1;
    rd_addr = 5'd5;
    rd_data = 32'h5555_5555;
    drive_read(5'd5, 5'd5, 32'h0, 32'h0);
    compare_reads("rst_wr_fwd");
    @(posedge clk);
    @(negedge clk);
    wr_en = 1'b0;
    #2;
    rst_n = 1'b1;
    drive_read(5'd5, 5'd31, 32'h0, 32'h0);
    compare_reads("post_rst");
    drive_read(5'd4, 5'd2, 32'h0, 32'h0);
    compare_reads("post_rst2");

    // Normal operation resumes after reset.
    do_write(1'b1, 5'd7, 32'hCAFE_F00D);
    drive_read(5'd7, 5'd31, 32'hCAFE_F00D, 32'h0);
    compare_reads("resume");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
